ad9512_spi_cfg: RTL and testbench

//   SPI write master that programs the AD9512 clock distribution chip from a fixed register table.

---
 rtl/ad9512_pkg.sv | 29 ++
 rtl/ad9512_cfg_rom.sv | 49 ++++
 rtl/ad9512_spi_cfg.sv | 162 ++++++++++++++++
 tb/tb_ad9512_spi_cfg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ad9512_pkg.sv
// Shared types and constants for the AD9512 SPI configuration master.
package ad9512_pkg;

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } ad9512_reg_t;

    localparam logic        INSTR_WR       = 1'b0;
    localparam logic [1:0]  W_1BYTE        = 2'b00;
    localparam logic [12:0] REG_UPDATE     = 13'h05A;
    localparam logic [12:0] REG_SERIAL_CFG = 13'h000;

    // IDLE wait | LOAD fetch | CSSU CSB setup | SHIFT 24 bits | CSHOLD | GAP CSB high | DONE
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CSSU,
        ST_SHIFT,
        ST_CSHOLD,
        ST_GAP,
        ST_DONE
    } cfg_state_t;

    function automatic logic [23:0] ad9512_frame(input ad9512_reg_t r);
        return {INSTR_WR, W_1BYTE, r.addr, r.data};
    endfunction

endpackage

// File: rtl/ad9512_cfg_rom.sv
// Board-specific AD9512 register table; the last used entry is always the update-registers write.
module ad9512_cfg_rom
    import ad9512_pkg::*;
#(
    parameter int N_REGS = 16,
    parameter int IDX_W  = 4
) (
    input  logic [IDX_W-1:0] i_idx,
    output ad9512_reg_t      o_reg
);

    function automatic ad9512_reg_t rom_entry(input int idx);
        ad9512_reg_t e;
        if (idx == N_REGS - 1) begin
            e = {REG_UPDATE, 8'h01};
        end else begin
            case (idx)
                0:       e = {REG_SERIAL_CFG, 8'h10};
                1:       e = {13'h034, 8'h00};
                2:       e = {13'h035, 8'h00};
                3:       e = {13'h036, 8'h00};
                4:       e = {13'h03D, 8'h08};
                5:       e = {13'h03E, 8'h08};
                6:       e = {13'h03F, 8'h08};
                7:       e = {13'h040, 8'h02};
                8:       e = {13'h041, 8'h02};
                9:       e = {13'h045, 8'h02};
                10:      e = {13'h04A, 8'h00};
                11:      e = {13'h04B, 8'h80};
                12:      e = {13'h04C, 8'h00};
                13:      e = {13'h04D, 8'h80};
                14:      e = {13'h058, 8'h00};
                default: e = {REG_SERIAL_CFG, 8'h10};
            endcase
        end
        return e;
    endfunction

    localparam ad9512_reg_t LAST_ENTRY = rom_entry(N_REGS - 1);

    if (LAST_ENTRY.addr != REG_UPDATE || LAST_ENTRY.data != 8'h01) begin : g_bad_last_entry
        $error("ad9512_cfg_rom: final table entry must be the 0x5A <= 0x01 update write");
    end

    always_comb begin
        o_reg = rom_entry(int'(i_idx));
    end

endmodule

// File: rtl/ad9512_spi_cfg.sv
// SPI write master replaying the AD9512 register table on reset and on each start rising edge.
module ad9512_spi_cfg
    import ad9512_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int N_REGS     = 16,
    parameter int CS_GAP     = 8,
    parameter int AUTO_START = 1,
    localparam int IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             spi_csb,
    output logic             spi_sclk,
    output logic             spi_sdio,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] cfg_idx
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(CS_GAP);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REGS - 1);
    localparam logic [4:0]       LAST_BIT = 5'd23;

    if (CLK_DIV < 2 || CS_GAP < 2 || N_REGS < 1) begin : g_bad_params
        $error("ad9512_spi_cfg: CLK_DIV and CS_GAP must be >= 2, N_REGS >= 1");
    end

    cfg_state_t       r_state;
    logic             r_start_q;
    logic             r_pending;
    logic             r_auto;
    logic [23:0]      r_shift;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_bit;
    logic [GAP_W-1:0] r_gap;
    logic             r_csb;
    logic             r_sclk;
    logic             r_busy;
    logic             r_done;
    logic [IDX_W-1:0] r_idx;

    ad9512_reg_t      w_rom;
    logic [23:0]      w_frame;
    logic             w_edge;

    ad9512_cfg_rom #(
        .N_REGS (N_REGS),
        .IDX_W  (IDX_W)
    ) u_rom (
        .i_idx (r_idx),
        .o_reg (w_rom)
    );

    assign w_frame = ad9512_frame(w_rom);
    assign w_edge  = start & ~r_start_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_start_q <= 1'b0;
        else       r_start_q <= start;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_auto    <= (AUTO_START != 0);
            r_shift   <= '0;
            r_div     <= '0;
            r_bit     <= '0;
            r_gap     <= '0;
            r_csb     <= 1'b1;
            r_sclk    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_idx     <= '0;
        end else begin
            if (w_edge && r_state != ST_IDLE) r_pending <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_edge || r_pending || r_auto) begin
                        r_state   <= ST_LOAD;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_auto    <= 1'b0;
                        r_pending <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_shift <= w_frame;
                    r_div   <= DIV_LOAD;
                    r_bit   <= '0;
                    r_csb   <= 1'b0;
                    r_state <= ST_CSSU;
                end
                ST_CSSU: begin
                    if (r_div == '0) begin
                        r_div   <= DIV_LOAD;
                        r_sclk  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_div != '0) begin
                        r_div <= r_div - 1'b1;
                    end else begin
                        r_div <= DIV_LOAD;
                        // data advances with SCLK falling so SDIO is settled for the next rise
                        if (r_sclk) begin
                            r_sclk <= 1'b0;
                            if (r_bit != LAST_BIT) r_shift <= {r_shift[22:0], 1'b0};
                        end else if (r_bit == LAST_BIT) begin
                            r_state <= ST_CSHOLD;
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            r_sclk <= 1'b1;
                        end
                    end
                end
                ST_CSHOLD: begin
                    if (r_div == '0) begin
                        r_csb   <= 1'b1;
                        r_shift <= '0;
                        r_gap   <= GAP_LOAD;
                        r_state <= ST_GAP;
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end else if (r_idx == IDX_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign spi_csb  = r_csb;
    assign spi_sclk = r_sclk;
    assign spi_sdio = r_shift[23];
    assign busy     = r_busy;
    assign done     = r_done;
    assign cfg_idx  = r_idx;

endmodule

// File: tb/tb_ad9512_spi_cfg.sv
// Directed bench: three configurations of the AD9512 SPI master observed by an SPI slave decoder.
module tb_ad9512_spi_cfg;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_m = 1'b0, start_s = 1'b0;
    logic csb_a, sclk_a, sdio_a, busy_a, done_a;
    logic csb_m, sclk_m, sdio_m, busy_m, done_m;
    logic csb_s, sclk_s, sdio_s, busy_s, done_s;
    logic [3:0] idx_a, idx_m;
    logic [0:0] idx_s;

    always #5 clk = ~clk;

    ad9512_spi_cfg #(.CLK_DIV(4), .N_REGS(16), .CS_GAP(8), .AUTO_START(1)) u_auto (
        .clk(clk), .reset(reset), .start(start_a), .spi_csb(csb_a), .spi_sclk(sclk_a),
        .spi_sdio(sdio_a), .busy(busy_a), .done(done_a), .cfg_idx(idx_a));

    ad9512_spi_cfg #(.CLK_DIV(4), .N_REGS(16), .CS_GAP(8), .AUTO_START(0)) u_man (
        .clk(clk), .reset(reset), .start(start_m), .spi_csb(csb_m), .spi_sclk(sclk_m),
        .spi_sdio(sdio_m), .busy(busy_m), .done(done_m), .cfg_idx(idx_m));

    ad9512_spi_cfg #(.CLK_DIV(2), .N_REGS(1), .CS_GAP(2), .AUTO_START(1)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .spi_csb(csb_s), .spi_sclk(sclk_s),
        .spi_sdio(sdio_s), .busy(busy_s), .done(done_s), .cfg_idx(idx_s));

    // SPI slave decoder for all three instances, sampled on the falling clk edge
    logic [2:0]  w_csb, w_sclk, w_sdio;
    assign w_csb  = {csb_s, csb_m, csb_a};
    assign w_sclk = {sclk_s, sclk_m, sclk_a};
    assign w_sdio = {sdio_s, sdio_m, sdio_a};

    int          cyc = 0;
    logic [2:0]  p_csb = 3'b111, p_sclk = 3'b000, p_sdio = 3'b000;
    logic [23:0] sh [3];
    int          bits [3], locnt [3], hicnt [3], lasthi [3], lastrise [3];
    int          per [3], viol [3], stray [3], nfr [3];
    logic [23:0] mw [3][128];
    int          mb [3][128], mlo [3][128], mhi [3][128];

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (w_csb[k]) begin
                if (!p_csb[k]) begin
                    mw[k][nfr[k] % 128]  = sh[k];
                    mb[k][nfr[k] % 128]  = bits[k];
                    mlo[k][nfr[k] % 128] = locnt[k];
                    mhi[k][nfr[k] % 128] = lasthi[k];
                    nfr[k]++;
                    hicnt[k] = 0;
                end
                hicnt[k]++;
                if (w_sclk[k] && !p_sclk[k]) stray[k]++;
            end else begin
                if (p_csb[k]) begin
                    lasthi[k] = hicnt[k];
                    sh[k]     = '0;
                    bits[k]   = 0;
                    locnt[k]  = 0;
                end
                locnt[k]++;
                if (w_sclk[k] && !p_sclk[k]) begin
                    if (bits[k] > 0) per[k] = cyc - lastrise[k];
                    lastrise[k] = cyc;
                    sh[k] = {sh[k][22:0], w_sdio[k]};
                    bits[k]++;
                end
                if (w_sclk[k] && p_sclk[k] && (w_sdio[k] != p_sdio[k])) viol[k]++;
            end
        end
        p_csb  = w_csb;
        p_sclk = w_sclk;
        p_sdio = w_sdio;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [23:0] exp_w [16];
    int fd_a, fd_m, fd_s, drop_m, nb, base, r1, r2, st0, hit;
    logic pd;

    initial begin
        exp_w = '{24'h000010, 24'h003400, 24'h003500, 24'h003600,
                  24'h003D08, 24'h003E08, 24'h003F08, 24'h004002,
                  24'h004102, 24'h004502, 24'h004A00, 24'h004B80,
                  24'h004C00, 24'h004D80, 24'h005800, 24'h005A01};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_csb", csb_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_sdio", sdio_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_idx", idx_a, 0);
        @(negedge clk);
        reset = 1'b0;

        // auto run, manual trigger at cycle 10 held for 5000 cycles, tiny config
        fd_a = 0; fd_m = 0; fd_s = 0; drop_m = 0;
        for (int n = 1; n <= 5100; n++) begin
            @(posedge clk);
            #1;
            if (n == 10) begin
                chk("man_busy_pre", busy_m, 0);
                start_m = 1'b1;
            end
            if (n == 11) chk("man_busy_rise", busy_m, 1);
            if (n == 3344) chk("auto_idx_last", idx_a, 15);
            if (n == 3345) chk("auto_idx_clr", idx_a, 0);
            if (n == 5010) start_m = 1'b0;
            if (done_a === 1'b1 && fd_a == 0) fd_a = n;
            if (done_s === 1'b1 && fd_s == 0) fd_s = n;
            if (done_m === 1'b1 && fd_m == 0) fd_m = n;
            if (fd_m != 0 && done_m !== 1'b1) drop_m++;
        end
        chk("auto_done_cyc", fd_a, 3345);
        chk("small_done_cyc", fd_s, 104);
        chk("man_done_cyc", fd_m, 3355);
        chk("man_done_held", drop_m, 0);
        chk("auto_frames", nfr[0], 16);
        chk("man_frames", nfr[1], 16);
        chk("small_frames", nfr[2], 1);
        for (int i = 0; i < 16; i++) chk($sformatf("auto_word%0d", i), mw[0][i], exp_w[i]);
        chk("man_word0", mw[1][0], exp_w[0]);
        nb = 0;
        for (int i = 0; i < 16; i++) if (mb[0][i] != 24 || mb[1][i] != 24) nb++;
        chk("bits24", nb, 0);
        chk("auto_csb_low", mlo[0][5], 200);
        chk("auto_gap_hi", mhi[0][5], 9);
        chk("auto_period", per[0], 8);
        chk("small_word", mw[2][0], 24'h005A01);
        chk("small_bits", mb[2][0], 24);
        chk("small_csb_low", mlo[2][0], 100);
        chk("small_period", per[2], 4);
        chk("sdio_stable", viol[0] + viol[1] + viol[2], 0);
        chk("stray_sclk", stray[0] + stray[1] + stray[2], 0);
        chk("man_busy_end", busy_m, 0);

        // trigger, then two edges while busy merge into exactly one rerun
        base = nfr[1]; r1 = 0; r2 = 0; pd = done_m;
        for (int p = 0; p <= 6800; p++) begin
            if (p > 0) begin
                @(posedge clk);
                #1;
            end
            if (p == 0 || p == 100 || p == 200) start_m = 1'b1;
            if (p == 1 || p == 101 || p == 201) start_m = 1'b0;
            if (p == 150) chk("rerun_busy_mid", busy_m, 1);
            if (p == 3346) chk("rerun_busy_idle", busy_m, 0);
            if (p == 3347) chk("rerun_busy_again", busy_m, 1);
            if (done_m === 1'b1 && pd !== 1'b1) begin
                if (r1 == 0) r1 = p;
                else if (r2 == 0) r2 = p;
            end
            pd = done_m;
        end
        chk("rerun_done1", r1, 3345);
        chk("rerun_done2", r2, 6691);
        chk("rerun_frames", nfr[1] - base, 32);
        chk("rerun_gap", mhi[1][(base + 16) % 128], 11);
        chk("rerun_word0", mw[1][(base + 16) % 128], exp_w[0]);
        chk("rerun_last", mw[1][(base + 31) % 128], exp_w[15]);

        // reset in the middle of bit 12 of frame 3, then auto restart from frame 0
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        base = nfr[0]; st0 = stray[0]; hit = 0;
        for (int w = 0; w < 2000 && hit == 0; w++) begin
            @(negedge clk);
            #1;
            if (nfr[0] == base + 3 && bits[0] == 13 && sclk_a === 1'b1) hit = 1;
        end
        chk("abort_hit", hit, 1);
        chk("abort_idx", idx_a, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_csb", csb_a, 1);
        chk("abort_sclk", sclk_a, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_idx_rst", idx_a, 0);
        @(negedge clk);
        reset = 1'b0;
        hit = 0;
        for (int w = 0; w < 1000 && hit == 0; w++) begin
            @(posedge clk);
            #1;
            if (nfr[0] >= base + 5) hit = 1;
        end
        chk("restart_seen", hit, 1);
        chk("abort_bits", mb[0][(base + 3) % 128], 13);
        chk("restart_word", mw[0][(base + 4) % 128], exp_w[0]);
        chk("restart_bits", mb[0][(base + 4) % 128], 24);
        chk("abort_stray", stray[0] - st0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
